// File: rtl/life_pkg.sv
// Shared types and defaults for the Game-of-Life sequencer.
package life_pkg;

  localparam int N_DEF       = 8;
  localparam int GEN_W_DEF   = 16;
  localparam int MAX_GEN_DEF = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAUSE,
    S_ADV,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [1:0] HALT_LIMIT   = 2'b00;
  localparam logic [1:0] HALT_EXTINCT = 2'b01;
  localparam logic [1:0] HALT_STILL   = 2'b10;
  localparam logic [1:0] HALT_PERIOD2 = 2'b11;

endpackage

// File: rtl/life_pattern_cmp.sv
// Pattern equality and all-zero detect between the live grid and one history register.
module life_pattern_cmp #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         a_zero
);

  assign eq     = (a == b);
  assign a_zero = (a == '0);

endmodule

// File: rtl/life_sequencer.sv
// Load/run/pause controller for an external Life cell array with halt detection.
// Optional: define LIFE_PERIOD_DETECT_EN to add a second history register and period-2 halting.
module life_sequencer
  import life_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int GEN_W   = GEN_W_DEF,
  parameter int MAX_GEN = MAX_GEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*N-1:0]     seed_in,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  output logic               life_load,
  output logic [N*N-1:0]     seed_out,
  output logic               life_en,
  input  logic [N*N-1:0]     cells,
  output logic [N*N-1:0]     frame,
  output logic [GEN_W-1:0]   gen_count,
  output logic               busy,
  output logic               done,
  output logic [1:0]         halt_cause
);

  localparam int W = N * N;

  state_e             state_q, state_d;
  logic [W-1:0]       seed_out_q, seed_out_d;
  logic [W-1:0]       frame_q, frame_d;
  logic [W-1:0]       prev_q, prev_d;
  logic [GEN_W-1:0]   gen_count_q, gen_count_d;
  logic [1:0]         halt_cause_q, halt_cause_d;
  logic               free_q, free_d;
  logic               stop_seen_q, stop_seen_d;

  logic               handshake;
  logic               is_still;
  logic               is_extinct;
  logic               is_period2;
  logic               is_limit;
  logic [GEN_W-1:0]   gen_inc;

  life_pattern_cmp #(.W(W)) u_cmp_prev (
    .a      (cells),
    .b      (prev_q),
    .eq     (is_still),
    .a_zero (is_extinct)
  );

`ifdef LIFE_PERIOD_DETECT_EN
  logic [W-1:0] prev2_q, prev2_d;
  logic         match_prev2;
  logic         zero_prev2;

  life_pattern_cmp #(.W(W)) u_cmp_prev2 (
    .a      (cells),
    .b      (prev2_q),
    .eq     (match_prev2),
    .a_zero (zero_prev2)
  );

  assign is_period2 = match_prev2 & ~is_still & ~zero_prev2 & (gen_inc >= GEN_W'(2));

  always_comb begin
    prev2_d = prev2_q;
    if (state_q == S_ADV) prev2_d = prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) prev2_q <= '0;
    else     prev2_q <= prev2_d;
  end
`else
  assign is_period2 = 1'b0;
`endif

  assign gen_inc   = gen_count_q + GEN_W'(1);
  assign is_limit  = (gen_inc >= GEN_W'(MAX_GEN));
  assign handshake = seed_valid & seed_ready;

  always_comb begin
    state_d      = state_q;
    seed_out_d   = seed_out_q;
    frame_d      = frame_q;
    prev_d       = prev_q;
    gen_count_d  = gen_count_q;
    halt_cause_d = halt_cause_q;
    free_d       = free_q;
    stop_seen_d  = stop_seen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (handshake) begin
          seed_out_d = seed_in;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        gen_count_d  = '0;
        frame_d      = seed_out_q;
        halt_cause_d = HALT_LIMIT;
        state_d      = S_PAUSE;
      end
      S_PAUSE: begin
        if (handshake) begin
          seed_out_d = seed_in;
          state_d    = S_LOAD;
        end else if (stop) begin
          state_d = S_PAUSE;
        end else if (start) begin
          free_d      = 1'b1;
          stop_seen_d = 1'b0;
          state_d     = S_ADV;
        end else if (step) begin
          free_d      = 1'b0;
          stop_seen_d = 1'b0;
          state_d     = S_ADV;
        end
      end
      S_ADV: begin
        prev_d      = cells;
        stop_seen_d = stop_seen_q | stop;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        frame_d = cells;
        if (gen_count_q < GEN_W'(MAX_GEN)) gen_count_d = gen_inc;
        // A stop seen during ADV or CHECK only takes effect once this generation is booked.
        if (is_extinct) begin
          halt_cause_d = HALT_EXTINCT;
          state_d      = S_DONE;
        end else if (is_still) begin
          halt_cause_d = HALT_STILL;
          state_d      = S_DONE;
        end else if (is_period2) begin
          halt_cause_d = HALT_PERIOD2;
          state_d      = S_DONE;
        end else if (is_limit) begin
          halt_cause_d = HALT_LIMIT;
          state_d      = S_DONE;
        end else if (!free_q || stop_seen_q || stop) begin
          state_d = S_PAUSE;
        end else begin
          stop_seen_d = 1'b0;
          state_d     = S_ADV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      seed_out_q   <= '0;
      frame_q      <= '0;
      prev_q       <= '0;
      gen_count_q  <= '0;
      halt_cause_q <= HALT_LIMIT;
      free_q       <= 1'b0;
      stop_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_out_q   <= seed_out_d;
      frame_q      <= frame_d;
      prev_q       <= prev_d;
      gen_count_q  <= gen_count_d;
      halt_cause_q <= halt_cause_d;
      free_q       <= free_d;
      stop_seen_q  <= stop_seen_d;
    end
  end

  assign seed_ready = (state_q == S_IDLE) || (state_q == S_PAUSE) || (state_q == S_DONE);
  assign life_load  = (state_q == S_LOAD);
  assign life_en    = (state_q == S_ADV);
  assign busy       = (state_q == S_ADV) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign seed_out   = seed_out_q;
  assign frame      = frame_q;
  assign gen_count  = gen_count_q;
  assign halt_cause = halt_cause_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer driving a behavioural 8x8 Life array with dead borders.
module tb_life_sequencer;

  localparam int N     = 8;
  localparam int GEN_W = 16;
  localparam int MAXG  = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      seed_in;
  logic             seed_valid;
  logic             seed_ready;
  logic             start, stop, step;
  logic             life_load;
  logic [63:0]      seed_out;
  logic             life_en;
  logic [63:0]      arr;
  logic [63:0]      frame;
  logic [GEN_W-1:0] gen_count;
  logic             busy, done;
  logic [1:0]       halt_cause;
  logic             en_clr;
  int               en_cnt;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  life_sequencer #(.N(N), .GEN_W(GEN_W), .MAX_GEN(MAXG)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .life_load  (life_load),
    .seed_out   (seed_out),
    .life_en    (life_en),
    .cells      (arr),
    .frame      (frame),
    .gen_count  (gen_count),
    .busy       (busy),
    .done       (done),
    .halt_cause (halt_cause)
  );

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt, rr, cc;
    logic alive;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              if (g[63 - (rr * 8 + cc)]) cnt++;
          end
        end
        alive = g[63 - (r * 8 + c)];
        n[63 - (r * 8 + c)] = alive ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (life_load)    arr <= seed_out;
    else if (life_en) arr <= life_next(arr);
  end

  always @(posedge clk) begin
    if (en_clr)       en_cnt <= 0;
    else if (life_en) en_cnt <= en_cnt + 1;
  end

  task automatic push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [63:0] obs);
    sb_t e;
    e = sb_q.pop_front();
    n_vec++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    assert (done === 1'b1) else begin
      n_err++;
      $error("FAIL wait_done observed=%b expected=1", done);
    end
  endtask

  task automatic load_seed(input logic [63:0] p, input string tag);
    seed_in    = p;
    seed_valid = 1'b1;
    push({tag, "_ready"}, 64'd1);
    check_next({63'd0, seed_ready});
    @(negedge clk);
    seed_valid = 1'b0;
    push({tag, "_life_load"}, 64'd1);
    check_next({63'd0, life_load});
    @(negedge clk);
    push({tag, "_gen0"}, 64'd0);
    push({tag, "_frame_seed"}, p);
    check_next({48'd0, gen_count});
    check_next(frame);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    push({tag, "_seed_ready"}, 64'd1);
    push({tag, "_done"}, 64'd0);
    push({tag, "_busy"}, 64'd0);
    push({tag, "_life_load"}, 64'd0);
    push({tag, "_life_en"}, 64'd0);
    push({tag, "_gen"}, 64'd0);
    push({tag, "_frame"}, 64'd0);
    push({tag, "_seed_out"}, 64'd0);
    push({tag, "_halt"}, 64'd0);
    check_next({63'd0, seed_ready});
    check_next({63'd0, done});
    check_next({63'd0, busy});
    check_next({63'd0, life_load});
    check_next({63'd0, life_en});
    check_next({48'd0, gen_count});
    check_next(frame);
    check_next(seed_out);
    check_next({62'd0, halt_cause});
  endtask

  initial begin
    logic [63:0] single, block, blinker, glider, g3;
    single  = 64'h00000010_00000000;
    block   = 64'h00000018_18000000;
    blinker = 64'h00000038_00000000;
    glider  = 64'h4020E000_00000000;
    g3 = glider;
    for (int i = 0; i < 3; i++) g3 = life_next(g3);

    rst = 1'b1; seed_in = '0; seed_valid = 1'b0;
    start = 1'b0; stop = 1'b0; step = 1'b0; en_clr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("por");

    // single live cell: dies after one generation
    load_seed(single, "single");
    push("single_halt", 64'd1);
    push("single_gen", 64'd1);
    push("single_frame", 64'd0);
    pulse_start();
    wait_done(20);
    check_next({62'd0, halt_cause});
    check_next({48'd0, gen_count});
    check_next(frame);

    // block: still life
    load_seed(block, "block");
    push("block_halt", 64'd2);
    push("block_gen", 64'd1);
    push("block_frame", block);
    push("block_ready_done", 64'd1);
    pulse_start();
    wait_done(20);
    check_next({62'd0, halt_cause});
    check_next({48'd0, gen_count});
    check_next(frame);
    check_next({63'd0, seed_ready});

    // blinker: period-2 or generation limit depending on build
    load_seed(blinker, "blinker");
`ifdef LIFE_PERIOD_DETECT_EN
    push("blinker_halt", 64'd3);
    push("blinker_gen", 64'd2);
`else
    push("blinker_halt", 64'd0);
    push("blinker_gen", MAXG);
`endif
    push("blinker_frame", blinker);
    pulse_start();
    wait_done(60);
    check_next({62'd0, halt_cause});
    check_next({48'd0, gen_count});
    check_next(frame);

    // glider stepped three times
    load_seed(glider, "gstep");
    en_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    start = 1'b1;
    push("gstep_gen", 64'd3);
    push("gstep_en_cnt", 64'd3);
    push("gstep_busy", 64'd0);
    push("gstep_ready", 64'd1);
    push("gstep_frame", g3);
    check_next({48'd0, gen_count});
    check_next(64'(en_cnt));
    check_next({63'd0, busy});
    check_next({63'd0, seed_ready});
    check_next(frame);
    start = 1'b0;

    // glider free-run, stop raised during the third ADV
    load_seed(glider, "gstop");
    pulse_start();
    repeat (4) @(negedge clk);
    push("gstop_adv_en", 64'd1);
    push("gstop_adv_gen", 64'd2);
    check_next({63'd0, life_en});
    check_next({48'd0, gen_count});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    push("gstop_check_busy", 64'd1);
    check_next({63'd0, busy});
    @(negedge clk);
    push("gstop_gen", 64'd3);
    push("gstop_ready", 64'd1);
    push("gstop_busy", 64'd0);
    push("gstop_frame", g3);
    check_next({48'd0, gen_count});
    check_next({63'd0, seed_ready});
    check_next({63'd0, busy});
    check_next(frame);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
    push("gboth_busy", 64'd0);
    push("gboth_gen", 64'd3);
    check_next({63'd0, busy});
    check_next({48'd0, gen_count});

    // reset while in CHECK, then a normal reload
    pulse_start();
    @(negedge clk);
    push("mid_check_busy", 64'd1);
    check_next({63'd0, busy});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    load_seed(block, "reload");
    push("reload_halt", 64'd2);
    push("reload_gen", 64'd1);
    pulse_start();
    wait_done(20);
    check_next({62'd0, halt_cause});
    check_next({48'd0, gen_count});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
